oam_dma: RTL and testbench

OAM DMA controller and bus arbiter sitting between the CPU and the system bus in front of the ppu. A CPU write to the DMA source register (0xFF46) starts a 160-byte copy from {src_hi, 0x00..0x9F} into sprite attribute memory at 0xFE00..0xFE9F. During the copy the block owns the bus and blocks CPU accesses, except for HRAM (0xFF80..0xFFFE) and the DMA register itself.

---
 rtl/oam_dma_if.sv | 32 +++
 rtl/oam_dma.sv | 146 ++++++++++++++
 tb/tb_oam_dma.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// CPU-side and system-bus-side signals of the OAM DMA arbiter.
// master is the arbiter's view; slave is the CPU/bus side.
interface oam_dma_if;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_indata;
  logic        cpu_load;
  logic        cpu_store;
  logic [7:0]  cpu_outdata;
  logic [15:0] bus_address;
  logic [7:0]  bus_outdata;
  logic [7:0]  bus_indata;
  logic        bus_load;
  logic        bus_store;

  modport master (
    input  cpu_address, cpu_indata,
    input  cpu_load, cpu_store,
    input  bus_indata,
    output cpu_outdata,
    output bus_address, bus_outdata,
    output bus_load, bus_store
  );

  modport slave (
    output cpu_address, cpu_indata,
    output cpu_load, cpu_store,
    output bus_indata,
    input  cpu_outdata,
    input  bus_address, bus_outdata,
    input  bus_load, bus_store
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA controller and CPU/bus arbiter.
// Copies LENGTH bytes from {src_hi,idx} into OAM.
module oam_dma #(
  parameter logic [15:0] SRC_REG   = 16'hff46,
  parameter logic [15:0] DEST_BASE = 16'hfe00,
  parameter int          LENGTH    = 160,
  parameter logic [15:0] HRAM_LO   = 16'hff80,
  parameter logic [15:0] HRAM_HI   = 16'hfffe
) (
  input  logic       clockgb,
  input  logic       resetn,
  oam_dma_if.master  bus,
  output logic       active,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE, READ, LATCH, WRITE
  } state_t;

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] byte_q, byte_d;
  logic       blocked_q, blocked_d;
  logic       reg_q, reg_d;
  logic       done_q, done_d;

  logic       reg_acc, reg_st;
  logic       cpu_req, cpu_hram;
  logic       cpu_gnt, stall;
  logic [7:0] src_eff;

  assign reg_acc  = bus.cpu_address == SRC_REG;
  assign reg_st   = reg_acc & bus.cpu_store;
  assign cpu_req  = (bus.cpu_load | bus.cpu_store)
                  & ~reg_acc;
  assign cpu_hram = (bus.cpu_address >= HRAM_LO)
                  & (bus.cpu_address <= HRAM_HI);
  assign cpu_gnt  = cpu_req
                  & ((state_q == IDLE) | cpu_hram);
  assign stall    = cpu_gnt
                  & ((state_q == READ)
                  |  (state_q == WRITE));

  // Echo RAM (0xE0xx..) aliases work RAM 0x20 pages down.
  assign src_eff = (src_hi_q >= 8'he0)
                 ? src_hi_q - 8'h20 : src_hi_q;

  assign active = state_q != IDLE;
  assign done   = done_q;

  // Bus mux: CPU pass-through unless the DMA owns the cycle.
  always_comb begin
    bus.bus_address = bus.cpu_address;
    bus.bus_outdata = bus.cpu_indata;
    bus.bus_load    = cpu_gnt & bus.cpu_load;
    bus.bus_store   = cpu_gnt & bus.cpu_store;
    if (!cpu_gnt) begin
      unique case (state_q)
        READ: begin
          bus.bus_address = {src_eff, idx_q};
          bus.bus_load    = 1'b1;
        end
        WRITE: begin
          bus.bus_address = DEST_BASE + {8'h00, idx_q};
          bus.bus_outdata = byte_q;
          bus.bus_store   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // CPU read data chosen by last cycle's access kind.
  always_comb begin
    unique case (1'b1)
      blocked_q: bus.cpu_outdata = 8'hff;
      reg_q:     bus.cpu_outdata = src_hi_q;
      default:   bus.cpu_outdata = bus.bus_indata;
    endcase
  end

  // Next-state: register write restarts, stalls hold.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_hi_d  = src_hi_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    blocked_d = cpu_req & bus.cpu_load & ~cpu_gnt;
    reg_d     = reg_acc & bus.cpu_load;
    if (reg_st) begin
      src_hi_d = bus.cpu_indata;
      idx_d    = 8'h00;
      state_d  = READ;
    end else begin
      unique case (state_q)
        IDLE: ;
        READ: begin
          if (!stall) state_d = LATCH;
        end
        LATCH: begin
          byte_d  = bus.bus_indata;
          state_d = WRITE;
        end
        WRITE: begin
          if (!stall) begin
            if (idx_q == LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 8'h01;
              state_d = READ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= 8'h00;
      src_hi_q  <= 8'h00;
      byte_q    <= 8'h00;
      blocked_q <= 1'b0;
      reg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      src_hi_q  <= src_hi_d;
      byte_q    <= byte_d;
      blocked_q <= blocked_d;
      reg_q     <= reg_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed testbench for oam_dma.
// Bus memory model with one-cycle read latency.
module tb_oam_dma;

  logic clk = 1'b0;
  logic rst_n;
  logic active, done;

  always #5 clk = ~clk;

  oam_dma_if bif();

  oam_dma dut (
    .clockgb (clk),
    .resetn  (rst_n),
    .bus     (bif),
    .active  (active),
    .done    (done)
  );

  logic [7:0] mem [0:65535];
  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;
  int n_done   = 0;
  int cyc      = 0;

  // Memory: reads return next cycle, 0 when no slave.
  always @(posedge clk) begin
    if (bif.bus_load)
      bif.bus_indata <= mem[bif.bus_address];
    else
      bif.bus_indata <= 8'h00;
    if (bif.bus_store)
      mem[bif.bus_address] <= bif.bus_outdata;
  end

  // Strobe and done-pulse counters.
  always @(posedge clk) begin
    if (bif.bus_load || bif.bus_store)
      n_strobe <= n_strobe + 1;
    if (done)
      n_done <= n_done + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cpu_idle();
    bif.cpu_address = 16'h0000;
    bif.cpu_indata  = 8'h00;
    bif.cpu_load    = 1'b0;
    bif.cpu_store   = 1'b0;
  endtask

  task automatic start(input logic [7:0] v);
    bif.cpu_address = 16'hff46;
    bif.cpu_indata  = v;
    bif.cpu_store   = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    cpu_idle();
  endtask

  task automatic fill(input logic [7:0] hi,
                      input logic [7:0] key);
    for (int i = 0; i < 160; i++)
      mem[{hi, 8'(i)}] = 8'(i) ^ key;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++)
      mem[16'hfe00 + 16'(i)] = 8'h00;
  endtask

  task automatic oam_bad(input logic [7:0] key,
                         output int nbad);
    nbad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hfe00 + 16'(i)] !== (8'(i) ^ key))
        nbad++;
  endtask

  task automatic wait_done(input string tag,
                           input int exp_cyc);
    int n = 0;
    while (!done && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_done_cyc"},
          done ? cyc : -1, exp_cyc);
    step();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_active_low"}, active, 0);
  endtask

  int nb, snap, stalls, bad;
  logic ours;

  initial begin
    cpu_idle();
    rst_n = 1'b0;
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'h00;
    mem[16'hc105] = 8'h9c;
    mem[16'hc000] = 8'h33;
    mem[16'hff90] = 8'h77;
    #1;
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_load", bif.bus_load, 0);
    check("rst_store", bif.bus_store, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // IDLE pass-through read
    bif.cpu_address = 16'hc105;
    bif.cpu_load    = 1'b1;
    #1;
    check("pt_load", bif.bus_load, 1);
    check("pt_addr", bif.bus_address, 16'hc105);
    step();
    cpu_idle();
    check("pt_data", bif.cpu_outdata, 8'h9c);

    // Basic copy from 0xC1
    fill(8'hc1, 8'h5a);
    clear_oam();
    start(8'hc1);
    check("t1_active", active, 1);
    check("t1_load", bif.bus_load, 1);
    check("t1_addr", bif.bus_address, 16'hc100);
    step();
    check("t1_latch_nostb",
          bif.bus_load | bif.bus_store, 0);
    step();
    check("t1_store", bif.bus_store, 1);
    check("t1_waddr", bif.bus_address, 16'hfe00);
    check("t1_wdata", bif.bus_outdata, 8'h5a);
    wait_done("t1", 481);
    oam_bad(8'h5a, nb);
    check("t1_oam", nb, 0);

    // Echo RAM source 0xE2 -> 0xC2
    fill(8'hc2, 8'ha5);
    fill(8'he2, 8'h11);
    clear_oam();
    start(8'he2);
    check("t2_addr", bif.bus_address, 16'hc200);
    wait_done("t2", 481);
    oam_bad(8'ha5, nb);
    check("t2_oam", nb, 0);

    // Blocked CPU load and store
    clear_oam();
    start(8'hc1);
    while (cyc < 10) step();
    bif.cpu_address = 16'hc000;
    bif.cpu_load    = 1'b1;
    #1;
    check("t3_blk_bus",
          (bif.bus_load | bif.bus_store)
          && bif.bus_address == 16'hc000, 0);
    step();
    cpu_idle();
    check("t3_blk_data", bif.cpu_outdata, 8'hff);
    while (cyc < 60) step();
    bif.cpu_address = 16'hfe10;
    bif.cpu_indata  = 8'hee;
    bif.cpu_store   = 1'b1;
    #1;
    check("t3_drop_bus",
          bif.bus_store && bif.bus_outdata == 8'hee,
          0);
    step();
    cpu_idle();
    wait_done("t3", 481);
    check("t3_oam10", mem[16'hfe10], 8'h4a);
    oam_bad(8'h5a, nb);
    check("t3_oam", nb, 0);

    // HRAM load stalls each READ
    clear_oam();
    start(8'hc1);
    stalls = 0;
    bad    = 0;
    ours   = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (!ours && bif.bus_load) begin
        bif.cpu_address = 16'hff90;
        bif.cpu_load    = 1'b1;
        #1;
        if (!(bif.bus_load &&
              bif.bus_address == 16'hff90))
          bad++;
        stalls++;
        ours = 1'b1;
      end else begin
        ours = 1'b0;
      end
      step();
      if (bif.cpu_load) begin
        cpu_idle();
        if (bif.cpu_outdata !== 8'h77) bad++;
        #1;
      end
    end
    check("t4_stalls", stalls, 160);
    check("t4_hram_bad", bad, 0);
    check("t4_done_cyc", done ? cyc : -1, 641);
    step();
    check("t4_active_low", active, 0);
    oam_bad(8'h5a, nb);
    check("t4_oam", nb, 0);

    // Restart at idx 50 with 0xD0
    fill(8'hd0, 8'hc3);
    clear_oam();
    snap = n_done;
    start(8'hc1);
    while (cyc < 151) step();
    check("t5_mid_addr", bif.bus_address, 16'hc132);
    start(8'hd0);
    check("t5_rs_load", bif.bus_load, 1);
    check("t5_rs_addr", bif.bus_address, 16'hd000);
    wait_done("t5", 481);
    check("t5_ndone", n_done - snap, 1);
    oam_bad(8'hc3, nb);
    check("t5_oam", nb, 0);
    bif.cpu_address = 16'hff46;
    bif.cpu_load    = 1'b1;
    #1;
    check("t5_reg_nofwd", bif.bus_load, 0);
    step();
    cpu_idle();
    check("t5_reg_rd", bif.cpu_outdata, 8'hd0);

    // Restart in the final WRITE cycle
    clear_oam();
    snap = n_done;
    start(8'hc1);
    while (cyc < 480) step();
    check("t6_last_st", bif.bus_store, 1);
    check("t6_last_addr",
          bif.bus_address, 16'hfe9f);
    start(8'hc1);
    check("t6_no_done", done, 0);
    check("t6_active", active, 1);
    check("t6_rs_addr", bif.bus_address, 16'hc100);
    wait_done("t6", 481);
    check("t6_ndone", n_done - snap, 1);

    // Reset at idx 80
    start(8'hc1);
    while (cyc < 241) step();
    rst_n = 1'b0;
    #1;
    check("t7_active", active, 0);
    check("t7_done", done, 0);
    check("t7_strobe",
          bif.bus_load | bif.bus_store, 0);
    step();
    step();
    rst_n = 1'b1;
    snap = n_strobe;
    for (int i = 0; i < 20; i++) step();
    check("t7_no_strobes", n_strobe - snap, 0);
    check("t7_idle", active, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
